// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types, widths and scaling constants for the ADC scan scheduler.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package adc_scan_scheduler_pkg;

  localparam int NUM_CH_DEFAULT  = 8;
  localparam int TIMEOUT_DEFAULT = 1023;

  localparam int VREF_MV  = 5000;
  localparam int ADC_FULL = 4095;

  localparam int ADC_W  = 12;
  localparam int MV_W   = 13;
  localparam int CH_W   = 5;
  localparam int IDX_W  = 3;
  // code * 5000 needs 25 bits (4095 * 5000 = 20,475,000 < 2^25)
  localparam int PROD_W = ADC_W + MV_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Truncating code-to-millivolt scaling: code * VREF_MV / ADC_FULL.
  function automatic logic [MV_W-1:0] code_to_mv(input logic [ADC_W-1:0] code);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(code) * PROD_W'(VREF_MV);
    return MV_W'(prod / PROD_W'(ADC_FULL));
  endfunction

endpackage

// File: rtl/adc_mv_convert.sv
// Registered ADC-code to millivolt conversion stage with index pass-through.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts one sample per cycle, output is a one-cycle strobe.
// Ports: clk, reset_n; in_valid/in_idx/in_code (12-bit code);
//        out_valid/out_idx/out_mv (13-bit millivolts).
module adc_mv_convert
  import adc_scan_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [ADC_W-1:0] in_code,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [MV_W-1:0]  out_mv
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_mv    <= '0;
    end else begin
      out_valid <= in_valid;
      // Index/value only move on a real sample so the bus stays quiet otherwise.
      if (in_valid) begin
        out_idx <= in_idx;
        out_mv  <= code_to_mv(in_code);
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC scan scheduler: issues one conversion at a time to the enabled
// channels, scales results to millivolts and keeps a per-channel readback table.
// Latency: response accepted in N -> upd_valid and table write in N+1, rd_mv in N+2.
// Backpressure: cmd held stable until cmd_ready; one command outstanding; WAIT times out.
// Ports: clk, reset_n; en_mask, run; cmd_valid/cmd_channel/cmd_ready;
//        rsp_valid/rsp_channel/rsp_data; rd_idx -> rd_mv; upd_valid/upd_idx/upd_mv;
//        busy; sticky timeout_err/chan_err cleared by err_clr.
module adc_scan_scheduler
  import adc_scan_scheduler_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic              run,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_channel,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [ADC_W-1:0]  rsp_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [MV_W-1:0]   rd_mv,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_idx,
  output logic [MV_W-1:0]   upd_mv,
  output logic              busy,
  output logic              timeout_err,
  output logic              chan_err,
  input  logic              err_clr
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  state_t           state;
  // Index of the channel being (or last) converted; reset to NUM_CH-1 so the
  // first search lands on index 0.
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] next_idx;
  logic [TW-1:0]    timer;
  logic             have_work;
  logic             rsp_accept;
  logic             chan_evt;
  logic             timeout_evt;
  logic [MV_W-1:0]  mv_tab [NUM_CH];

  // First enabled index strictly after 'last', wrapping; a lone enabled
  // channel finds itself on the final iteration.
  function automatic logic [IDX_W-1:0] pick_next(input logic [IDX_W-1:0] last,
                                                 input logic [NUM_CH-1:0] mask);
    logic [IDX_W-1:0] r;
    logic             hit;
    int               c;
    r   = last;
    hit = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(last) + k) % NUM_CH;
      if (!hit && mask[c]) begin
        r   = IDX_W'(c);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    next_idx    = pick_next(cur_idx, en_mask);
    have_work   = run && (en_mask != '0);
    rsp_accept  = (state == ST_WAIT) && rsp_valid && (rsp_channel == cmd_channel);
    chan_evt    = (state == ST_WAIT) && rsp_valid && (rsp_channel != cmd_channel);
    timeout_evt = (state == ST_WAIT) && !rsp_accept && (timer == T_MAX);
  end

  assign cmd_valid = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cur_idx     <= IDX_W'(NUM_CH - 1);
      cmd_channel <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      chan_err    <= 1'b0;
    end else begin
      // A new error event wins over a simultaneous clear.
      timeout_err <= (timeout_err & ~err_clr) | timeout_evt;
      chan_err    <= (chan_err & ~err_clr) | chan_evt;
      case (state)
        ST_IDLE: begin
          if (have_work) begin
            cur_idx     <= next_idx;
            cmd_channel <= CH_W'(next_idx) + CH_W'(1);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          if (cmd_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rsp_accept || timeout_evt) begin
            if (have_work) begin
              cur_idx     <= next_idx;
              cmd_channel <= CH_W'(next_idx) + CH_W'(1);
              state       <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  adc_mv_convert u_conv (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rsp_accept),
    .in_idx    (cur_idx),
    .in_code   (rsp_data),
    .out_valid (upd_valid),
    .out_idx   (upd_idx),
    .out_mv    (upd_mv)
  );

  // Table write and registered read. The read forwards a same-cycle update so
  // rd_mv shows a fresh value one cycle after upd_valid rather than two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) mv_tab[i] <= '0;
      rd_mv <= '0;
    end else begin
      if (upd_valid) mv_tab[upd_idx] <= upd_mv;
      if (int'(rd_idx) >= NUM_CH)
        rd_mv <= '0;
      else if (upd_valid && (upd_idx == rd_idx))
        rd_mv <= upd_mv;
      else
        rd_mv <= mv_tab[rd_idx];
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: directed scenarios push expected
// commands/updates into queues; a monitor pops and compares on each handshake/strobe.
// Ports exercised: all; TIMEOUT shortened to 15 to make the timeout path reachable.
module tb_adc_scan_scheduler;
  import adc_scan_scheduler_pkg::*;

  localparam int NCH  = 8;
  localparam int TOUT = 15;

  logic             clk;
  logic             reset_n;
  logic [NCH-1:0]   en_mask;
  logic             run;
  logic             cmd_valid;
  logic [CH_W-1:0]  cmd_channel;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [CH_W-1:0]  rsp_channel;
  logic [ADC_W-1:0] rsp_data;
  logic [IDX_W-1:0] rd_idx;
  logic [MV_W-1:0]  rd_mv;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [MV_W-1:0]  upd_mv;
  logic             busy;
  logic             timeout_err;
  logic             chan_err;
  logic             err_clr;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [MV_W-1:0]  mv;
  } upd_exp_t;

  logic [CH_W-1:0] exp_cmd_q[$];
  upd_exp_t        exp_upd_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int n_cmd_acc = 0;

  adc_scan_scheduler #(.NUM_CH(NCH), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_mask     (en_mask),
    .run         (run),
    .cmd_valid   (cmd_valid),
    .cmd_channel (cmd_channel),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_channel (rsp_channel),
    .rsp_data    (rsp_data),
    .rd_idx      (rd_idx),
    .rd_mv       (rd_mv),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_mv      (upd_mv),
    .busy        (busy),
    .timeout_err (timeout_err),
    .chan_err    (chan_err),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted command and every update strobe must
  // match the head of its expectation queue.
  initial begin
    logic [CH_W-1:0] ec;
    upd_exp_t        eu;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (cmd_valid && cmd_ready) begin
          n_cmd_acc++;
          if (exp_cmd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd: got channel %0d expected none", cmd_channel);
          end else begin
            ec = exp_cmd_q.pop_front();
            check("cmd_channel", 32'(cmd_channel), 32'(ec));
          end
        end
        if (upd_valid) begin
          if (exp_upd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_upd: got idx %0d mv %0d expected none", upd_idx, upd_mv);
          end else begin
            eu = exp_upd_q.pop_front();
            check("upd_idx", 32'(upd_idx), 32'(eu.idx));
            check("upd_mv", 32'(upd_mv), 32'(eu.mv));
          end
        end
      end
    end
  end

  // Waits for a command handshake; returns just after the accepting edge.
  task automatic wait_cmd(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no command expected one within 60 cycles", name);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADC model: answers dly cycles later with a one-cycle response.
  task automatic respond(input int dly, input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] data);
    repeat (dly) @(posedge clk);
    #1;
    rsp_valid   = 1'b1;
    rsp_channel = ch;
    rsp_data    = data;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  initial begin
    int acc0;
    reset_n     = 1'b0;
    en_mask     = '0;
    run         = 1'b0;
    cmd_ready   = 1'b1;
    rsp_valid   = 1'b0;
    rsp_channel = '0;
    rsp_data    = '0;
    rd_idx      = '0;
    err_clr     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_channel", 32'(cmd_channel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_mv", 32'(rd_mv), 0);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_flags", 32'({timeout_err, chan_err}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Two-channel scan at full scale; run drops during the last WAIT.
    exp_cmd_q.push_back(5'd1);
    exp_cmd_q.push_back(5'd3);
    exp_cmd_q.push_back(5'd1);
    exp_cmd_q.push_back(5'd3);
    exp_upd_q.push_back('{idx: 3'd0, mv: 13'd5000});
    exp_upd_q.push_back('{idx: 3'd2, mv: 13'd5000});
    exp_upd_q.push_back('{idx: 3'd0, mv: 13'd5000});
    exp_upd_q.push_back('{idx: 3'd2, mv: 13'd5000});
    en_mask = 8'b0000_0101;
    run     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd("scan_cmd");
      if (i == 3) run = 1'b0;
      respond(3, (i % 2 == 0) ? 5'd1 : 5'd3, 12'd4095);
    end
    repeat (4) @(negedge clk);
    check("stop_busy", 32'(busy), 0);
    check("stop_cmd_valid", 32'(cmd_valid), 0);
    rd_idx = 3'd0;
    @(negedge clk);
    check("rd_idx0", 32'(rd_mv), 5000);
    rd_idx = 3'd1;
    @(negedge clk);
    check("rd_idx1", 32'(rd_mv), 0);
    rd_idx = 3'd2;
    @(negedge clk);
    check("rd_idx2", 32'(rd_mv), 5000);

    // Empty mask with run high stays idle.
    en_mask = '0;
    run     = 1'b1;
    repeat (5) @(negedge clk);
    check("nomask_busy", 32'(busy), 0);
    check("nomask_cmd_valid", 32'(cmd_valid), 0);

    // cmd_ready held low: command stays put, mask change ignored mid-ISSUE.
    cmd_ready = 1'b0;
    exp_cmd_q.push_back(5'd2);
    exp_upd_q.push_back('{idx: 3'd1, mv: 13'd2500});
    en_mask = 8'b0000_0010;
    rd_idx  = 3'd1;
    repeat (2) @(negedge clk);
    en_mask = 8'b0000_0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(cmd_valid), 1);
      check("hold_channel", 32'(cmd_channel), 2);
    end
    acc0 = n_cmd_acc;
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) @(negedge clk);
    check("one_cmd_accepted", 32'(n_cmd_acc - acc0), 1);
    check("wait_busy", 32'(busy), 1);

    // Wrong-channel responses, then the right one with mid-scale data.
    @(posedge clk);
    #1;
    rsp_valid   = 1'b1;
    rsp_channel = 5'd4;
    rsp_data    = 12'd100;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check("chan_err_set", 32'(chan_err), 1);
    check("chan_err_stay_wait", 32'(busy), 1);
    @(posedge clk);
    #1;
    rsp_valid = 1'b1;
    err_clr   = 1'b1;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);
    check("clr_vs_set", 32'(chan_err), 1);
    run = 1'b0;
    respond(1, 5'd2, 12'd2048);
    @(negedge clk);
    check("rd_before_update", 32'(rd_mv), 0);
    @(negedge clk);
    check("rd_after_update", 32'(rd_mv), 2500);
    repeat (3) @(negedge clk);
    check("after_rsp_idle", 32'(busy), 0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("chan_err_cleared", 32'(chan_err), 0);

    // Timeout on index 2, then advance to index 0.
    exp_cmd_q.push_back(5'd3);
    exp_cmd_q.push_back(5'd1);
    exp_upd_q.push_back('{idx: 3'd0, mv: 13'd0});
    en_mask = 8'b0000_0101;
    run     = 1'b1;
    rd_idx  = 3'd2;
    wait_cmd("to_cmd");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) check("timeout_not_yet", 32'(timeout_err), 0);
    end
    @(negedge clk);
    check("timeout_set", 32'(timeout_err), 1);
    check("timeout_next_valid", 32'(cmd_valid), 1);
    check("timeout_next_channel", 32'(cmd_channel), 1);
    check("timeout_table_kept", 32'(rd_mv), 5000);
    run = 1'b0;
    @(posedge clk);
    #1;
    respond(3, 5'd1, 12'd0);
    repeat (3) @(negedge clk);
    check("timeout_scan_idle", 32'(busy), 0);

    // Reset in the middle of WAIT.
    exp_cmd_q.push_back(5'd3);
    en_mask = 8'b0000_0100;
    run     = 1'b1;
    wait_cmd("pre_reset_cmd");
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    run     = 1'b0;
    en_mask = 8'b0000_0101;
    @(negedge clk);
    check("mid_rst_cmd_valid", 32'(cmd_valid), 0);
    check("mid_rst_cmd_channel", 32'(cmd_channel), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_mv", 32'(rd_mv), 0);
    check("mid_rst_flags", 32'({timeout_err, chan_err}), 0);
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    rsp_valid   = 1'b1;
    rsp_channel = 5'd3;
    rsp_data    = 12'd4095;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_rsp_no_err", 32'(chan_err), 0);
    check("stale_rsp_idle", 32'(busy), 0);
    check("table_cleared", 32'(rd_mv), 0);
    exp_cmd_q.push_back(5'd1);
    exp_upd_q.push_back('{idx: 3'd0, mv: 13'd5000});
    run = 1'b1;
    wait_cmd("restart_cmd");
    run = 1'b0;
    respond(3, 5'd1, 12'd4095);
    repeat (3) @(negedge clk);
    check("final_idle", 32'(busy), 0);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
    check("upd_queue_drained", 32'(exp_upd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 Parameter NUM_CH, default 8: number of scannable ADC inputs, index 0..NUM_CH-1.
REQ-002 Parameter TIMEOUT, default 1023: maximum WAIT cycles before a conversion is abandoned.
REQ-003 Clk  in  1  sole clock, the ADC system clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 en_mask  in  NUM_CH  channel enable bits, 1 = include in scan.
REQ-006 run  in  1  1 = continuous scan; 0 = finish the current conversion, then idle.
REQ-007 cmd_valid / cmd_channel / cmd_ready  out 1 / out 5 / in 1  ADC command handshake.
REQ-008 rsp_valid / rsp_channel / rsp_data  in 1 / in 5 / in 12  ADC response.
REQ-009 rd_idx  in  3  read-port channel index.
REQ-010 rd_mv  out  13  registered millivolt value of channel rd_idx.
REQ-011 upd_valid / upd_idx / upd_mv  out 1 / out 3 / out 13  one-cycle update strobe with index and value.
REQ-012 busy  out  1  high in ISSUE or WAIT.
REQ-013 timeout_err / chan_err  out 1 / out 1  sticky error flags.
REQ-014 err_clr  in  1  clears both sticky flags.

Function
REQ-015 States: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when run = 1 and en_mask != 0.
- ISSUE -> WAIT on the cmd_valid && cmd_ready cycle.
- WAIT -> ISSUE or IDLE on an accepted response or on timeout.
REQ-016 Channel selection: the next enabled index strictly after the last converted index, wrapping NUM_CH-1 -> 0. The first selection after reset starts the search at index 0. A single enabled channel reselects itself.
REQ-017 en_mask is sampled only at selection; changes during ISSUE or WAIT do not disturb the current conversion.
REQ-018 cmd_channel = selected index + 1 (ADC_IN0 maps to ADC channel 1).
- cmd_valid is high only in ISSUE.
- cmd_channel is stable while cmd_valid is high, until cmd_ready.
REQ-019 Exactly one command is outstanding at a time.
REQ-020 In WAIT, a response is accepted when rsp_valid = 1 and rsp_channel = expected cmd_channel.
- A mismatched rsp_valid is discarded, sets chan_err, and the block stays in WAIT.
- rsp_valid outside WAIT is ignored.
REQ-021 Conversion: mv = rsp_data * 5000 / 4095, truncated, 13 bits.
- 4095 -> 5000; 0 -> 0; 2048 -> 2500.
- Intermediate product width is at least 25 bits.
REQ-022 Latency: a response accepted in cycle N gives a one-cycle upd_valid and a per-channel table write in cycle N+1. rd_mv reflects the new value at N+2.
REQ-023 After TIMEOUT+1 cycles in WAIT without an accepted response:
- set timeout_err;
- write no table entry and raise no upd_valid;
- advance to the next channel.
REQ-024 Leaving WAIT: go to ISSUE if run = 1 and en_mask != 0, else to IDLE.
REQ-025 If err_clr and a new error event occur in the same cycle, the flag ends set.
REQ-026 rd_mv is registered: rd_idx sampled in cycle N gives its value in N+1. rd_idx >= NUM_CH returns 0.

Reset
REQ-027 Reset forces:
- state = IDLE, last index = NUM_CH-1 (so the first search yields index 0);
- every table entry = 0;
- all outputs 0, including cmd_channel, rd_mv, upd_* and both flags.
REQ-028 Reset asserted mid-conversion abandons it immediately. A response arriving after reset release is ignored, as IDLE ignores it.

Structure
REQ-029 A shared package holds:
- state enumeration;
- NUM_CH_DEFAULT, TIMEOUT_DEFAULT;
- VREF_MV = 5000, ADC_FULL = 4095;
- widths ADC_W = 12, MV_W = 13, CH_W = 5.
REQ-030 One sub-module, adc_mv_convert, holds the registered code-to-millivolt stage (12 bits in, 13 bits out, 1-cycle latency).

Verification
REQ-031 en_mask = 8'b0000_0101, run = 1, ADC model answers after 3 cycles with data 4095 -> commands on channels 1, 3, 1, 3; upd_mv = 5000 for idx 0 and 2.
REQ-032 cmd_ready held low for 10 cycles -> cmd_valid and cmd_channel stay constant; exactly one command is accepted.
REQ-033 Response with rsp_channel = 4 while expecting 2, then a correct response with data 2048 -> chan_err = 1, one upd_valid, upd_mv = 2500.
REQ-034 No response, TIMEOUT = 15 -> timeout_err set on cycle 16 of WAIT, table unchanged, next channel issued.
REQ-035 run dropped during WAIT -> conversion completes, then IDLE with cmd_valid = 0; en_mask = 0 with run = 1 -> stays IDLE.
REQ-036 reset_n pulsed low during WAIT -> all outputs 0 and table 0 immediately; after release the scan restarts at index 0.
